alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Parametrised successor to the combinational ALU opcode decoder. Accepts one opcode at a time through a valid/ready handshake and registers a one-hot operation select. It holds that select for an operation-specific number of cycles (multi-cycle multiply/divide), then presents a completion handshake to the result stage. It also flags illegal opcodes and counts completed operations. It sits between the instruction/control front end and the ALU datapath of the FPGA ULA.

Parameters:
OP_W, 3, opcode width in bits.
NUM_OPS, 8, number of legal opcodes (0..NUM_OPS-1); must be <= 2**OP_W.
MUL_CODE, 2, opcode of multiply.
DIV_CODE, 3, opcode of divide.
MUL_LAT, 4, cycles the select is held in BUSY for multiply (>=1).
DIV_LAT, 8, cycles the select is held in BUSY for divide (>=1).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
op_in  input  OP_W  opcode, sampled on accept.
op_valid  input  1  opcode present.
op_ready  output  1  sequencer can accept; high only in IDLE.
sel  output  2**OP_W  one-hot operation select; bit k selects opcode k.
busy  output  1  high in BUSY and DONE.
op_err  output  1  completing opcode was >= NUM_OPS; valid with out_valid.
out_valid  output  1  operation complete; high in DONE.
out_ready  input  1  result stage consumes completion.
op_count  output  CNT_W  number of completed legal and illegal ops; wraps modulo 2**CNT_W.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, sel=0, busy=0, op_err=0, out_valid=0, op_count=0, op_ready=1 in the following cycle. Reset wins over every other event, including mid-BUSY or mid-DONE; an in-flight op is dropped and not counted.
- FSM has 3 states: IDLE, BUSY, DONE.
- IDLE: op_ready=1, sel=0. Accept = op_valid & op_ready at edge T.
  - Latch the opcode, load latency counter with LAT-1, and go to BUSY at T+1.
  - LAT = MUL_LAT if op==MUL_CODE, DIV_LAT if op==DIV_CODE, 1 otherwise (also for illegal opcodes).
- BUSY: sel = one-hot of latched opcode, or all-zero if opcode >= NUM_OPS. busy=1. Counter decrements each cycle. When counter==0, go to DONE next edge. BUSY therefore lasts exactly LAT cycles (T+1..T+LAT).
- DONE (first cycle T+LAT+1): out_valid=1, sel held, op_err = (opcode >= NUM_OPS). Holds until out_valid & out_ready at an edge; then IDLE next cycle, op_count increments by 1, sel/op_err clear.
- out_ready is ignored outside DONE. op_valid is ignored outside IDLE; no overlap or pipelining, and the opcode must be re-presented by the source.
- out_ready already high on entering DONE gives a 1-cycle DONE. Minimum op period: LAT+2 cycles from accept to the next possible accept.
- sel is always one-hot or zero, never multi-hot. The counter width is sized internally to hold max(MUL_LAT,DIV_LAT)-1.
- op_count wraps from 2**CNT_W-1 to 0 without error.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then op_in=0, op_valid=1 accepted at cycle 10 -> sel=8'b0000_0001 at cycles 11-12, out_valid=1 at cycle 12, with out_ready=1 -> op_ready=1 at 13, op_count=1.
- op_in=2 (multiply) accepted at cycle 20 -> sel=8'b0000_0100 for cycles 21-24 with out_valid=0, out_valid=1 at 25. op_in=3 accepted -> out_valid exactly 9 cycles after accept.
- op_in=7 accepted with out_ready=0 for 5 cycles -> out_valid/sel=8'b1000_0000 held steady through the stall, op_ready=0 throughout. op_valid toggling with op_in=1 during the stall is ignored, and op_count is unchanged until out_ready=1.
- NUM_OPS=6, op_in=6 -> sel=0 during BUSY/DONE, op_err=1 with out_valid, op_count increments, and the next legal op gives op_err=0.
- rst=1 in the 2nd BUSY cycle of a divide -> next cycle IDLE, sel=0, busy=0, out_valid never asserted, op_count unchanged.
- CNT_W=4, 16 back-to-back single-cycle ops -> op_count wraps 15->0. Sweep all 8 opcodes and check sel is one-hot and matches the opcode each time.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Opcode sequencer: accepts one opcode via valid/ready, holds a one-hot select
// for an opcode-dependent latency, then offers a completion handshake.
module alu_op_sequencer #(
  parameter int OP_W     = 3,
  parameter int NUM_OPS  = 8,
  parameter int MUL_CODE = 2,
  parameter int DIV_CODE = 3,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      op_in,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic [2**OP_W-1:0]   sel,
  output logic                 busy,
  output logic                 op_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     op_count
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       lat_cnt;
  logic                illegal_q;
  logic                illegal_in;
  logic [CW-1:0]       lat_load;
  logic [2**OP_W-1:0]  sel_next;

  always_comb begin
    illegal_in = 32'(op_in) >= 32'(NUM_OPS);
    sel_next   = '0;
    if (!illegal_in) sel_next[op_in] = 1'b1;
    if (op_in == OP_W'(MUL_CODE))      lat_load = CW'(MUL_LAT - 1);
    else if (op_in == OP_W'(DIV_CODE)) lat_load = CW'(DIV_LAT - 1);
    else                               lat_load = '0;
  end

  // Handshake outputs decode straight from state, so no input reaches an output
  assign op_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      illegal_q <= 1'b0;
      sel       <= '0;
      op_err    <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          lat_cnt   <= lat_load;
          illegal_q <= illegal_in;
          sel       <= sel_next;
          state     <= BUSY;
        end
        BUSY: if (lat_cnt == '0) begin
          op_err <= illegal_q;
          state  <= DONE;
        end else begin
          lat_cnt <= lat_cnt - CW'(1);
        end
        DONE: if (out_ready) begin
          sel      <= '0;
          op_err   <= 1'b0;
          op_count <= op_count + CNT_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
